// File: rtl/add_serial_seq_if.sv
// Handshake and datapath bundle for add_serial_seq.
// The master side is the sequencer itself; the slave side is its environment
// (upstream producer, downstream serial adder and result consumer).
interface add_serial_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_en;
  logic [WIDTH-1:0] add_out;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic [7:0]       done_cnt;

  modport master (
    input  in_valid, in_a, in_b, add_out, out_ready,
    output in_ready, add_a, add_b, add_en, out_valid, out_data, busy, done_cnt
  );

  modport slave (
    output in_valid, in_a, in_b, add_out, out_ready,
    input  in_ready, add_a, add_b, add_en, out_valid, out_data, busy, done_cnt
  );
endinterface

// File: rtl/add_serial_seq.sv
// Sequencer for a multi-cycle serial adder: accepts an operand pair, holds
// add_en high for EN_CYC cycles, waits until the adder result is settled
// (LAT cycles after the first strobe cycle), captures it and holds it until
// the consumer takes it. One transaction in flight at a time.
module add_serial_seq #(
  parameter int WIDTH  = 8,
  parameter int EN_CYC = 2,
  parameter int LAT    = 12
) (
  input  logic clk,
  input  logic rst,
  add_serial_seq_if.master sif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  // Issue counter runs EN_CYC-1..0 so add_en is high for exactly EN_CYC cycles.
  // Wait counter runs LAT-EN_CYC-1..0 so the capture edge ends cycle LAT-1,
  // counting the first add_en-high cycle as cycle 0.
  localparam logic [CNT_W-1:0] ISSUE_LOAD = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(LAT - EN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] wait_cnt;

  // Transaction FSM; every interface output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      issue_cnt     <= '0;
      wait_cnt      <= '0;
      sif.in_ready  <= 1'b1;
      sif.busy      <= 1'b0;
      sif.add_en    <= 1'b0;
      sif.add_a     <= '0;
      sif.add_b     <= '0;
      sif.out_valid <= 1'b0;
      sif.out_data  <= '0;
      sif.done_cnt  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (sif.in_valid) begin
            sif.add_a    <= sif.in_a;
            sif.add_b    <= sif.in_b;
            issue_cnt    <= ISSUE_LOAD;
            sif.add_en   <= 1'b1;
            sif.in_ready <= 1'b0;
            sif.busy     <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_cnt == '0) begin
            wait_cnt   <= WAIT_LOAD;
            sif.add_en <= 1'b0;
            state      <= WAIT;
          end else begin
            issue_cnt <= issue_cnt - CNT_ONE;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            sif.out_data  <= sif.add_out;
            sif.out_valid <= 1'b1;
            state         <= HOLD;
          end else begin
            wait_cnt <= wait_cnt - CNT_ONE;
          end
        end
        HOLD: begin
          // Handoff returns to IDLE; the next pair is taken no earlier than
          // the following edge, which guarantees one IDLE cycle in between.
          if (sif.out_ready) begin
            sif.out_valid <= 1'b0;
            sif.done_cnt  <= sif.done_cnt + 8'd1;
            sif.in_ready  <= 1'b1;
            sif.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_serial_seq.sv
// Directed testbench for add_serial_seq (WIDTH=8, EN_CYC=2, LAT=12).
module tb_add_serial_seq;
  localparam int WIDTH  = 8;
  localparam int EN_CYC = 2;
  localparam int LAT    = 12;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  add_serial_seq_if #(.WIDTH(WIDTH)) bus ();

  add_serial_seq #(.WIDTH(WIDTH), .EN_CYC(EN_CYC), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .sif (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.in_valid  = 1'b0;
    bus.in_a      = 8'h00;
    bus.in_b      = 8'h00;
    bus.add_out   = 8'h00;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Waits (bounded) for in_ready, presents one pair for one cycle.
  // Returns in cycle 0 (first add_en-high cycle).
  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait in_ready=%b expected 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    tick;
    bus.in_valid = 1'b0;
  endtask

  // From cycle 0, drive the adder result only in cycle LAT-1 (garbage elsewhere).
  task automatic drive_to_capture(input logic [7:0] sum);
    for (int c = 0; c < LAT; c++) begin
      bus.add_out = (c == LAT - 1) ? sum : ~sum;
      tick;
    end
  endtask

  task automatic handoff;
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    do_reset();
    checks++;
    if ({bus.in_ready, bus.busy, bus.add_en, bus.out_valid, bus.done_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_release ready/busy/en/valid/cnt=%b%b%b%b/%0d expected 1000/0",
               bus.in_ready, bus.busy, bus.add_en, bus.out_valid, bus.done_cnt);
    end
    accept(8'h5A, 8'hA5);
    tick;
    tick;
    checks++;
    if ({bus.busy, bus.add_a} !== {1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL reset_precond busy=%b add_a=%h expected 1/5a", bus.busy, bus.add_a);
    end
    // Assert reset mid-cycle, well away from any rising edge.
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.add_a, bus.add_b, bus.out_data, bus.done_cnt} !== 32'h0) begin
      errors++;
      $display("FAIL async_reset_data add_a=%h add_b=%h out_data=%h done_cnt=%0d expected all 0",
               bus.add_a, bus.add_b, bus.out_data, bus.done_cnt);
    end
    checks++;
    if ({bus.add_en, bus.out_valid, bus.busy, bus.in_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL async_reset_ctrl en/valid/busy/ready=%b%b%b%b expected 0001",
               bus.add_en, bus.out_valid, bus.busy, bus.in_ready);
    end
    tick;
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset in_ready=%b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_single_op;
    int en = 0;
    int early = 0;
    accept(8'h12, 8'h34);
    checks++;
    if ({bus.add_a, bus.add_b, bus.add_en, bus.in_ready, bus.busy} !== {8'h12, 8'h34, 3'b101}) begin
      errors++;
      $display("FAIL single_issue add_a=%h add_b=%h en=%b ready=%b busy=%b expected 12/34/1/0/1",
               bus.add_a, bus.add_b, bus.add_en, bus.in_ready, bus.busy);
    end
    for (int c = 0; c < LAT; c++) begin
      if (bus.add_en === 1'b1) en++;
      if (bus.out_valid !== 1'b0) early++;
      bus.add_out = (c == LAT - 1) ? 8'h46 : 8'h00;
      tick;
    end
    checks++;
    if (en != EN_CYC) begin
      errors++;
      $display("FAIL single_en_cycles got %0d expected %0d", en, EN_CYC);
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL single_early_valid got %0d cycles expected 0", early);
    end
    checks++;
    if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h46}) begin
      errors++;
      $display("FAIL single_result valid=%b data=%h expected 1/46", bus.out_valid, bus.out_data);
    end
    handoff();
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.done_cnt} !== {2'b01, 8'd1}) begin
      errors++;
      $display("FAIL single_handoff valid=%b ready=%b done_cnt=%0d expected 0/1/1",
               bus.out_valid, bus.in_ready, bus.done_cnt);
    end
  endtask

  task automatic test_backpressure;
    accept(8'h21, 8'h0F);
    drive_to_capture(8'h30);
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'hFF;
    bus.in_b      = 8'hFF;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({bus.out_valid, bus.out_data, bus.add_a, bus.add_b, bus.in_ready, bus.add_en}
          !== {1'b1, 8'h30, 8'h21, 8'h0F, 2'b00}) begin
        errors++;
        $display("FAIL backpressure cyc %0d valid=%b data=%h add_a=%h add_b=%h ready=%b en=%b expected 1/30/21/0f/0/0",
                 i, bus.out_valid, bus.out_data, bus.add_a, bus.add_b, bus.in_ready, bus.add_en);
      end
      bus.add_out = 8'($urandom);
      tick;
    end
    bus.in_valid = 1'b0;
    handoff();
    checks++;
    if (bus.done_cnt !== 8'd2) begin
      errors++;
      $display("FAIL backpressure_cnt done_cnt=%0d expected 2", bus.done_cnt);
    end
  endtask

  task automatic test_capture;
    // out_ready with nothing to hand off must be ignored.
    bus.out_ready = 1'b1;
    repeat (3) tick;
    bus.out_ready = 1'b0;
    checks++;
    if ({bus.out_valid, bus.done_cnt} !== {1'b0, 8'd2}) begin
      errors++;
      $display("FAIL stray_out_ready valid=%b done_cnt=%0d expected 0/2", bus.out_valid, bus.done_cnt);
    end
    accept(8'h01, 8'h02);
    for (int c = 0; c < LAT; c++) begin
      bus.add_out = (c <= 10) ? 8'hAA : ((c == 11) ? 8'h55 : 8'hC3);
      tick;
    end
    bus.add_out = 8'hC3;
    checks++;
    if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h55}) begin
      errors++;
      $display("FAIL capture_edge valid=%b data=%h expected 1/55", bus.out_valid, bus.out_data);
    end
    repeat (3) tick;
    bus.add_out = 8'h77;
    tick;
    checks++;
    if (bus.out_data !== 8'h55) begin
      errors++;
      $display("FAIL capture_stable data=%h expected 55", bus.out_data);
    end
    handoff();
    checks++;
    if (bus.done_cnt !== 8'd3) begin
      errors++;
      $display("FAIL capture_cnt done_cnt=%0d expected 3", bus.done_cnt);
    end
  endtask

  task automatic test_abort;
    int bad = 0;
    accept(8'h40, 8'h02);
    repeat (5) tick;
    checks++;
    if ({bus.busy, bus.add_en, bus.out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL abort_precond busy/en/valid=%b%b%b expected 100", bus.busy, bus.add_en, bus.out_valid);
    end
    #2;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({bus.out_valid, bus.done_cnt} !== {1'b0, 8'd0}) begin
      errors++;
      $display("FAIL abort_state valid=%b done_cnt=%0d expected 0/0", bus.out_valid, bus.done_cnt);
    end
    bus.add_out = 8'h42;
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
      tick;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_no_result got %0d active cycles expected 0", bad);
    end
    accept(8'h33, 8'h11);
    drive_to_capture(8'h44);
    checks++;
    if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h44}) begin
      errors++;
      $display("FAIL abort_next_op valid=%b data=%h expected 1/44", bus.out_valid, bus.out_data);
    end
    handoff();
    checks++;
    if (bus.done_cnt !== 8'd1) begin
      errors++;
      $display("FAIL abort_next_cnt done_cnt=%0d expected 1", bus.done_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] va [3] = '{8'h10, 8'h7F, 8'hF0};
    logic [7:0] vb [3] = '{8'h05, 8'h01, 8'h20};
    logic [7:0] sum;
    bus.in_valid  = 1'b1;
    bus.in_a      = va[0];
    bus.in_b      = vb[0];
    bus.out_ready = 1'b1;
    tick;
    for (int i = 0; i < 3; i++) begin
      sum = va[i] + vb[i];
      checks++;
      if ({bus.add_a, bus.add_b, bus.add_en} !== {va[i], vb[i], 1'b1}) begin
        errors++;
        $display("FAIL b2b_issue %0d add_a=%h add_b=%h en=%b expected %h/%h/1",
                 i, bus.add_a, bus.add_b, bus.add_en, va[i], vb[i]);
      end
      if (i < 2) begin
        bus.in_a = va[i+1];
        bus.in_b = vb[i+1];
      end
      drive_to_capture(sum);
      checks++;
      if ({bus.out_valid, bus.out_data} !== {1'b1, sum}) begin
        errors++;
        $display("FAIL b2b_result %0d valid=%b data=%h expected 1/%h", i, bus.out_valid, bus.out_data, sum);
      end
      tick;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.add_en, bus.add_a, bus.done_cnt}
          !== {3'b010, va[i], 8'(2 + i)}) begin
        errors++;
        $display("FAIL b2b_gap %0d valid=%b ready=%b en=%b add_a=%h done_cnt=%0d expected 0/1/0/%h/%0d",
                 i, bus.out_valid, bus.in_ready, bus.add_en, bus.add_a, bus.done_cnt, va[i], 2 + i);
      end
      if (i == 2) begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
      end
      tick;
    end
  endtask

  task automatic test_wrap;
    logic [7:0] a;
    logic [7:0] sum;
    idle_inputs();
    do_reset();
    for (int i = 0; i < 257; i++) begin
      a   = 8'(i);
      sum = a + 8'h3C;
      accept(a, 8'h3C);
      drive_to_capture(sum);
      checks++;
      if (bus.out_data !== sum) begin
        errors++;
        $display("FAIL wrap_data op %0d data=%h expected %h", i, bus.out_data, sum);
      end
      handoff();
      if (i == 254 || i == 255 || i == 256) begin
        checks++;
        if (bus.done_cnt !== 8'(i + 1)) begin
          errors++;
          $display("FAIL wrap_cnt op %0d done_cnt=%0d expected %0d", i, bus.done_cnt, (i + 1) % 256);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_op();
    test_backpressure();
    test_capture();
    test_abort();
    test_back_to_back();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_serial_seq.md
ADD_SERIAL_SEQ -- requirements
Module: add_serial_seq

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width.
REQ-002 Parameter EN_CYC, default 2, SHALL set the number of consecutive cycles add_en is high per issue (range 1..4).
REQ-003 Parameter LAT, default 12, SHALL set the cycles from the first add_en-high cycle to result capture (LAT >= EN_CYC+1).
REQ-004 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 in_valid  input  1  upstream operand pair valid.
REQ-007 in_ready  output  1  block can accept an operand pair.
REQ-008 in_a, in_b  input  WIDTH each  operand pair, sampled on acceptance.
REQ-009 add_a, add_b  output  WIDTH each  registered operands driven to the downstream serial adder.
REQ-010 add_en  output  1  registered start strobe to the serial adder.
REQ-011 add_out  input  WIDTH  serial adder result.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out_data  output  WIDTH  captured result.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done_cnt  output  8  count of completed results handed off.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD; encoded in a 2-bit state register.
REQ-018 IDLE: in_ready=1; on in_valid: latch in_a->add_a, in_b->add_b, load issue counter with EN_CYC-1, next state ISSUE.
REQ-019 ISSUE: add_en=1 every cycle in this state; decrement issue counter; on 0, load wait counter with LAT-EN_CYC-1, next state WAIT.
REQ-020 WAIT: add_en=0; decrement wait counter; on 0, capture add_out into out_data, set out_valid, next state HOLD.
REQ-021 Net effect: add_out SHALL be sampled on the edge ending cycle LAT-1, counting the first add_en-high cycle as cycle 0.
REQ-022 HOLD: out_valid=1, out_data stable; on out_ready: clear out_valid, increment done_cnt, next state IDLE.
REQ-023 in_ready SHALL be 0 outside IDLE; in_valid there is ignored and in_a/in_b are not sampled.
REQ-024 add_a/add_b SHALL change only on acceptance and hold their values through ISSUE, WAIT, HOLD, and following IDLE.
REQ-025 out_ready while out_valid=0 SHALL have no effect.
REQ-026 A new pair SHALL not be accepted in the same cycle a result is handed off (minimum one IDLE cycle between transactions).
REQ-027 done_cnt SHALL wrap 255->0 without side effect.
REQ-028 add_out changes outside the capture edge SHALL not alter out_data.
REQ-029 Counters SHALL be sized ceil(log2(LAT)) bits; no underflow is possible in legal parameter ranges.

Reset
REQ-030 On rst high, immediately and regardless of clk: state=IDLE, add_en=0, out_valid=0, out_data=0, add_a=0, add_b=0, done_cnt=0, counters=0.
REQ-031 rst asserted mid-ISSUE/WAIT/HOLD SHALL abort the transaction; no result is produced and done_cnt is not incremented.
REQ-032 After rst deasserts, in_ready SHALL be 1 in the first cycle.

Verification
REQ-033 Reset: drive rst=1 mid-cycle with no clk edge -> all outputs 0 and in_ready=1 immediately.
REQ-034 Single op: in_a=8'h12, in_b=8'h34, in_valid one cycle -> add_a=8'h12, add_b=8'h34 next cycle; add_en high exactly 2 cycles; bench model drives add_out=8'h46 at cycle 11 -> out_valid rises with out_data=8'h46; out_ready -> done_cnt=1.
REQ-035 Backpressure: hold out_ready=0 for 20 cycles with in_valid=1 and in_a=8'hFF -> out_data, add_a unchanged, in_ready=0, add_en=0 throughout.
REQ-036 Capture timing: add_out=8'hAA through cycle 10, 8'h55 at cycle 11, 8'hC3 from cycle 12 -> out_data=8'h55.
REQ-037 Abort: assert rst during WAIT -> out_valid stays 0, done_cnt=0, next op completes normally.
REQ-038 Wrap: 256 back-to-back transactions -> done_cnt returns to 0; 257th -> done_cnt=1.
